// File: rtl/sevenseg_pkg.sv
// Shared FSM state type and segment constants for the two-digit scan driver.
// Patterns are logical (1 = segment lit), bit order {g,f,e,d,c,b,a}.
package sevenseg_pkg;

    typedef enum logic [1:0] {
        StOnesOn,
        StGuardA,
        StTensOn,
        StGuardB
    } state_e;

    localparam logic [6:0] SEG_OFF  = 7'h00;
    localparam logic [6:0] SEG_DASH = 7'h40;

    // Index is the decimal digit; element 0 is the rightmost entry.
    localparam logic [9:0][6:0] DIGIT_PAT = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic is_on(input state_e s);
        return (s == StOnesOn) || (s == StTensOn);
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD to logical seven-segment pattern; codes 10-15 show a dash.
module seg_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] pat_o
);

    always_comb begin
        pat_o = SEG_DASH;
        for (int i = 0; i < 10; i++) begin
            if (bcd_i == 4'(i)) pat_o = DIGIT_PAT[i];
        end
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Two-digit multiplexed seven-segment driver with anode dead time between digits.
// Optional macro LEADING_ZERO_BLANK_EN keeps the tens anode off when the tens digit is 0.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned GUARD_CYCLES = 16,
    parameter int unsigned ACTIVE_LOW   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam int unsigned CntMax = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam bit          HasGuard = (GUARD_CYCLES != 0);

    localparam logic [CntW-1:0] OnLoad    = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] GuardLoad = HasGuard ? CntW'(GUARD_CYCLES - 1) : '0;
    localparam state_e          ResetState = HasGuard ? StGuardB : StOnesOn;
    localparam logic [CntW-1:0] ResetCnt   = HasGuard ? GuardLoad : OnLoad;

    localparam logic [6:0] SegInv = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [1:0] AnInv  = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      pend_q, pend_d;
    logic [7:0]      act_q, act_d;
    logic [6:0]      seg_q, seg_d;
    logic [1:0]      an_q, an_d;
    logic            frame_tick_q, frame_tick_d;

    logic       entering_on;
    logic [7:0] shown_pair;
    logic [3:0] digit;
    logic [6:0] pat;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
            case (state_q)
                StOnesOn: state_d = HasGuard ? StGuardA : StTensOn;
                StGuardA: state_d = StTensOn;
                StTensOn: state_d = HasGuard ? StGuardB : StOnesOn;
                default:  state_d = StOnesOn;
            endcase
            cnt_d = is_on(state_d) ? OnLoad : GuardLoad;
        end

        pend_d = load ? {tens, ones} : pend_q;

        // Snapshot on slot entry uses the pre-load pending value so a slot never tears.
        entering_on = (state_d != state_q) && is_on(state_d);
        act_d       = entering_on ? pend_q : act_q;
        shown_pair  = entering_on ? pend_q : act_q;
        digit       = (state_d == StTensOn) ? shown_pair[7:4] : shown_pair[3:0];
    end

    seg_decode u_seg_decode (
        .bcd_i (digit),
        .pat_o (pat)
    );

    always_comb begin
        logic [1:0] sel;
        sel = 2'b00;
        case (state_d)
            StOnesOn: sel = 2'b01;
            StTensOn: begin
                sel = 2'b10;
`ifdef LEADING_ZERO_BLANK_EN
                if (shown_pair[7:4] == 4'd0) sel = 2'b00;
`endif
            end
            default:  sel = 2'b00;
        endcase
        if (blank) sel = 2'b00;

        an_d         = sel ^ AnInv;
        seg_d        = (is_on(state_d) ? pat : SEG_OFF) ^ SegInv;
        frame_tick_d = (state_d == StOnesOn) && (state_q != StOnesOn);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ResetState;
            cnt_q        <= ResetCnt;
            pend_q       <= '0;
            act_q        <= '0;
            seg_q        <= SEG_OFF ^ SegInv;
            an_q         <= AnInv;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            act_q        <= act_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan (REFRESH_DIV=4, GUARD_CYCLES=1, ACTIVE_LOW=1).
// Reference tracks position in the 10-cycle frame and the digit pair latched at each slot start.
module tb_sevenseg_scan;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       load  = 1'b0;
    logic       blank = 1'b0;
    logic [3:0] tens  = 4'd0;
    logic [3:0] ones  = 4'd0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: k = edges since reset release (0 while in reset).
    int         k        = 0;
    logic [3:0] m_pend_t = 4'd0;
    logic [3:0] m_pend_o = 4'd0;
    logic [3:0] m_show_t = 4'd0;
    logic [3:0] m_show_o = 4'd0;
    logic       m_blank  = 1'b0;

    sevenseg_scan #(
        .REFRESH_DIV  (4),
        .GUARD_CYCLES (1),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .tens       (tens),
        .ones       (ones),
        .blank      (blank),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_pat(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Frame: positions 0-3 ones, 4 guard, 5-8 tens, 9 guard.
    function automatic int phase();
        return (k - 1) % 10;
    endfunction

    function automatic logic [6:0] exp_seg();
        if (k == 0) return 7'h7F;
        if (phase() < 4) return ~ref_pat(m_show_o);
        if (phase() >= 5 && phase() < 9) return ~ref_pat(m_show_t);
        return 7'h7F;
    endfunction

    function automatic logic [1:0] exp_an();
        if (k == 0 || m_blank) return 2'b11;
        if (phase() < 4) return 2'b10;
        if (phase() >= 5 && phase() < 9) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (m_show_t == 4'd0) return 2'b11;
`endif
            return 2'b01;
        end
        return 2'b11;
    endfunction

    function automatic logic exp_ft();
        return (k > 0) && (phase() == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst) begin
            k        = 0;
            m_pend_t = 4'd0;
            m_pend_o = 4'd0;
        end else begin
            k++;
            if (phase() == 0) m_show_o = m_pend_o;
            if (phase() == 5) m_show_t = m_pend_t;
            if (load) begin
                m_pend_t = tens;
                m_pend_o = ones;
            end
        end
        m_blank = blank;
        #1;
    endtask

    task automatic pulse_load(input logic [3:0] t, input logic [3:0] o);
        tens = t;
        ones = o;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_phase(input int target);
        for (int i = 0; i < 12 && !(k > 0 && phase() == target); i++) tick();
        checks++;
        if (!(k > 0 && phase() == target)) begin
            errors++;
            $display("FAIL wait_phase: phase=%0d required=%0d", phase(), target);
        end
    endtask

    task automatic test_reset();
        int pulses;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({seg, an, frame_tick} !== {7'h7F, 2'b11, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold: seg=%h an=%b ft=%b, required seg=7f an=11 ft=0",
                         seg, an, frame_tick);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (an !== 2'b10 || frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_slot: an=%b ft=%b, required an=10 ft=1", an, frame_tick);
        end
        pulses = 1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (frame_tick === 1'b1) pulses++;
            checks++;
            if ({seg, an, frame_tick} !== {exp_seg(), exp_an(), exp_ft()}) begin
                errors++;
                $display("FAIL reset_scan cyc=%0d: seg=%h an=%b ft=%b, required seg=%h an=%b ft=%b",
                         cyc, seg, an, frame_tick, exp_seg(), exp_an(), exp_ft());
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL reset_tick_count: pulses=%0d required=1", pulses);
        end
    endtask

    task automatic test_digits();
        int first_ft;
        int period;
        first_ft = -1;
        period   = -1;
        pulse_load(4'd4, 4'd2);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (frame_tick === 1'b1) begin
                if (first_ft < 0) first_ft = cyc;
                else if (period < 0) period = cyc - first_ft;
            end
            checks++;
            if ({seg, an, frame_tick} !== {exp_seg(), exp_an(), exp_ft()}) begin
                errors++;
                $display("FAIL digits_42 cyc=%0d: seg=%h an=%b ft=%b, required seg=%h an=%b ft=%b",
                         cyc, seg, an, frame_tick, exp_seg(), exp_an(), exp_ft());
            end
        end
        checks++;
        if (period != 10) begin
            errors++;
            $display("FAIL frame_period: period=%0d required=10", period);
        end
    endtask

    task automatic test_dash();
        pulse_load(4'd4, 4'd12);
        for (int i = 0; i < 22; i++) begin
            tick();
            checks++;
            if ({seg, an, frame_tick} !== {exp_seg(), exp_an(), exp_ft()}) begin
                errors++;
                $display("FAIL dash cyc=%0d: seg=%h an=%b ft=%b, required seg=%h an=%b ft=%b",
                         cyc, seg, an, frame_tick, exp_seg(), exp_an(), exp_ft());
            end
        end
        wait_phase(0);
        checks++;
        if (seg !== 7'h3F) begin
            errors++;
            $display("FAIL dash_pattern: seg=%h required=3f", seg);
        end
    endtask

    task automatic test_no_tear();
        wait_phase(6);
        pulse_load(4'd5, 4'd12);
        checks++;
        if (seg !== 7'h19) begin
            errors++;
            $display("FAIL tear_hold: seg=%h required=19", seg);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({seg, an, frame_tick} !== {exp_seg(), exp_an(), exp_ft()}) begin
                errors++;
                $display("FAIL no_tear cyc=%0d: seg=%h an=%b ft=%b, required seg=%h an=%b ft=%b",
                         cyc, seg, an, frame_tick, exp_seg(), exp_an(), exp_ft());
            end
        end
        wait_phase(5);
        checks++;
        if (seg !== 7'h12) begin
            errors++;
            $display("FAIL tear_next_slot: seg=%h required=12", seg);
        end
    endtask

    task automatic test_leading_zero();
        pulse_load(4'd0, 4'd7);
        for (int i = 0; i < 22; i++) begin
            tick();
            checks++;
            if ({seg, an, frame_tick} !== {exp_seg(), exp_an(), exp_ft()}) begin
                errors++;
                $display("FAIL lead_zero cyc=%0d: seg=%h an=%b ft=%b, required seg=%h an=%b ft=%b",
                         cyc, seg, an, frame_tick, exp_seg(), exp_an(), exp_ft());
            end
        end
    endtask

    task automatic test_blank();
        wait_phase(1);
        blank = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({seg, an, frame_tick} !== {exp_seg(), exp_an(), exp_ft()}) begin
                errors++;
                $display("FAIL blank_on cyc=%0d: seg=%h an=%b ft=%b, required seg=%h an=%b ft=%b",
                         cyc, seg, an, frame_tick, exp_seg(), exp_an(), exp_ft());
            end
        end
        blank = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ({seg, an, frame_tick} !== {exp_seg(), exp_an(), exp_ft()}) begin
                errors++;
                $display("FAIL blank_off cyc=%0d: seg=%h an=%b ft=%b, required seg=%h an=%b ft=%b",
                         cyc, seg, an, frame_tick, exp_seg(), exp_an(), exp_ft());
            end
        end
    endtask

    task automatic test_reset_mid();
        wait_phase(6);
        pulse_load(4'd9, 4'd9);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({seg, an, frame_tick} !== {7'h7F, 2'b11, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: seg=%h an=%b ft=%b, required seg=7f an=11 ft=0",
                     seg, an, frame_tick);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (seg !== 7'h40 || an !== 2'b10) begin
            errors++;
            $display("FAIL reset_pending_clear: seg=%h an=%b, required seg=40 an=10", seg, an);
        end
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++;
            if ({seg, an, frame_tick} !== {exp_seg(), exp_an(), exp_ft()}) begin
                errors++;
                $display("FAIL reset_mid cyc=%0d: seg=%h an=%b ft=%b, required seg=%h an=%b ft=%b",
                         cyc, seg, an, frame_tick, exp_seg(), exp_an(), exp_ft());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load  = ($urandom_range(0, 7) == 0);
            tens  = 4'($urandom_range(0, 15));
            ones  = 4'($urandom_range(0, 15));
            blank = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if ({seg, an, frame_tick} !== {exp_seg(), exp_an(), exp_ft()}) begin
                errors++;
                $display("FAIL random cyc=%0d: seg=%h an=%b ft=%b, required seg=%h an=%b ft=%b",
                         cyc, seg, an, frame_tick, exp_seg(), exp_an(), exp_ft());
            end
        end
        load  = 1'b0;
        blank = 1'b0;
    endtask

    initial begin
        test_reset();
        test_digits();
        test_dash();
        test_no_tear();
        test_leading_zero();
        test_blank();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
